// File: rtl/alu_miter_sweeper_pkg.sv
// Shared definitions for the ALU miter sweeper.
// Contents: FSM state encoding, LFSR tap constant, captured-vector width and
// the one-step Galois LFSR helper used by the LFSR sub-module.
package alu_miter_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          FAIL_VEC_W = 41;

  // Galois LFSR, shift right: the bit leaving at [0] folds the taps back in.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/alu_miter_sweeper_if.sv
// Control/stimulus/result bundle between the sweeper and its surroundings.
// master: the sweeper (takes start/abort/miter_out, drives stimulus + status).
// slave : host logic and the miter (drives start/abort/miter_out).
//   start, abort, miter_out        : host/miter -> sweeper
//   a, b, opcode, carry_in         : stimulus to the miter
//   busy, done, pass, err_count,
//   fail_vec, fail_valid           : sweep status and first-failure capture
interface alu_miter_sweeper_if;
  import alu_miter_sweeper_pkg::*;

  logic                  start;
  logic                  abort;
  logic                  miter_out;
  logic [15:0]           a;
  logic [15:0]           b;
  logic [7:0]            opcode;
  logic                  carry_in;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [15:0]           err_count;
  logic [FAIL_VEC_W-1:0] fail_vec;
  logic                  fail_valid;

  modport master (
    input  start, abort, miter_out,
    output a, b, opcode, carry_in, busy, done, pass, err_count, fail_vec, fail_valid
  );

  modport slave (
    output start, abort, miter_out,
    input  a, b, opcode, carry_in, busy, done, pass, err_count, fail_vec, fail_valid
  );

endinterface

// File: rtl/alu_miter_sweeper_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
// Ports: clk, rst (async active-high, loads SEED), load_i (reload SEED,
// wins over step_i), step_i (advance one step), value_o (current state).
module alu_miter_sweeper_lfsr16
  import alu_miter_sweeper_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Next LFSR value: reload, step or hold.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = SEED;
    end else if (step_i) begin
      value_d = lfsr_step(value_q);
    end else begin
      value_d = value_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/alu_miter_sweeper.sv
// On-chip sweeper for the ALU miter: walks every opcode, driving
// VECS_PER_OP LFSR-derived vectors each, counts miter disagreements and
// captures the first failing vector.
// Ports: clk, reset (async active-high), bus (alu_miter_sweeper_if.master).
// Each vector takes two cycles: DRIVE registers the stimulus, SAMPLE reads
// miter_out after the stimulus has been stable for a full cycle.
module alu_miter_sweeper
  import alu_miter_sweeper_pkg::*;
#(
  parameter int          NUM_OPS     = 22,
  parameter int          VECS_PER_OP = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  alu_miter_sweeper_if.master        bus
);

  localparam logic [7:0]  OP_LAST  = 8'(NUM_OPS - 1);
  localparam logic [15:0] VEC_LAST = 16'(VECS_PER_OP - 1);

  state_e                state_q, state_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [15:0]           vec_cnt_q, vec_cnt_d;
  logic [15:0]           a_q, a_d;
  logic [15:0]           b_q, b_d;
  logic                  cin_q, cin_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [15:0]           err_q, err_d;
  logic [FAIL_VEC_W-1:0] fvec_q, fvec_d;
  logic                  fvalid_q, fvalid_d;

  logic                  lfsr_load_s;
  logic                  lfsr_step_s;
  logic [8:0]            lfsr_s;
  logic [6:0]            lfsr_unused_s;

  alu_miter_sweeper_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (reset),
    .load_i  (lfsr_load_s),
    .step_i  (lfsr_step_s),
    .value_o ({lfsr_unused_s, lfsr_s})
  );

  // Sweep sequencing: next state, counters, stimulus and result registers.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    vec_cnt_d   = vec_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fvec_d      = fvec_q;
    fvalid_d    = fvalid_q;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;

    if (bus.abort) begin
      // Counters and capture are kept so the host can inspect a partial run.
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d     = ST_DRIVE;
            lfsr_load_s = 1'b1;
            opcode_d    = 8'd0;
            vec_cnt_d   = 16'd0;
            err_d       = 16'd0;
            fvalid_d    = 1'b0;
            fvec_d      = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            busy_d      = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        ST_DRIVE: begin
          a_d         = {12'h000, lfsr_s[3:0]};
          b_d         = {12'h000, lfsr_s[7:4]};
          cin_d       = lfsr_s[8];
          lfsr_step_s = 1'b1;
          state_d     = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (!bus.miter_out) begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end else begin
              err_d = err_q;
            end
            if (!fvalid_q) begin
              fvec_d   = {opcode_q, a_q, b_q, cin_q};
              fvalid_d = 1'b1;
            end else begin
              fvec_d   = fvec_q;
            end
          end else begin
            err_d = err_q;
          end
          if (vec_cnt_q == VEC_LAST) begin
            vec_cnt_d = 16'd0;
            if (opcode_q == OP_LAST) begin
              // Last vector: opcode stays on the final value for inspection.
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_d == 16'd0);
            end else begin
              opcode_d = opcode_q + 8'd1;
              state_d  = ST_DRIVE;
            end
          end else begin
            vec_cnt_d = vec_cnt_q + 16'd1;
            state_d   = ST_DRIVE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= 8'd0;
      vec_cnt_q <= 16'd0;
      a_q       <= 16'd0;
      b_q       <= 16'd0;
      cin_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 16'd0;
      fvec_q    <= '0;
      fvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      vec_cnt_q <= vec_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fvec_q    <= fvec_d;
      fvalid_q  <= fvalid_d;
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.opcode     = opcode_q;
  assign bus.carry_in   = cin_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_vec   = fvec_q;
  assign bus.fail_valid = fvalid_q;

endmodule

// File: tb/tb_alu_miter_sweeper.sv
// Self-checking bench for alu_miter_sweeper. A sweep-level model (vector
// table indexed by cycles since start) predicts every output each cycle.
module tb_alu_miter_sweeper;

  localparam int NUM_OPS   = 22;
  localparam int VECS      = 10;
  localparam int TOTAL     = NUM_OPS * VECS;
  localparam int SWEEP_CYC = 2 * TOTAL;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_miter_sweeper_if bus();

  alu_miter_sweeper #(
    .NUM_OPS     (NUM_OPS),
    .VECS_PER_OP (VECS),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected stimulus sequence of one sweep.
  logic [15:0] va [TOTAL];
  logic [15:0] vb [TOTAL];
  logic        vc [TOTAL];

  // Model state.
  logic        m_active;
  int          m_t;
  logic [15:0] m_a, m_b, m_err;
  logic [7:0]  m_op;
  logic        m_cin, m_busy, m_done, m_pass, m_fvalid;
  logic [40:0] m_fvec;

  int   fail_mode;   // 0: none fail, 1: opcode 5 fails, 2: all fail
  logic idle_miter;  // miter_out value outside SAMPLE cycles
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic fails(input int j);
    if (fail_mode == 2) return 1'b1;
    if (fail_mode == 1) return (j / VECS) == 5;
    return 1'b0;
  endfunction

  function automatic logic cur_miter();
    if (m_active && (m_t % 2 == 1)) return !fails((m_t - 1) / 2);
    return idle_miter;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_t = 0;
    m_a = '0; m_b = '0; m_cin = 1'b0; m_op = '0;
    m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
    m_err = '0; m_fvec = '0; m_fvalid = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs present before it.
  task automatic model_edge(input logic st, input logic ab, input logic mo);
    int j;
    if (rst) return;
    if (ab) begin
      m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
    end else if (m_active) begin
      m_t++;
      if (m_t % 2 == 1) begin
        j = (m_t - 1) / 2;
        m_a = va[j]; m_b = vb[j]; m_cin = vc[j]; m_op = 8'(j / VECS);
      end else begin
        j = (m_t - 2) / 2;
        if (!mo) begin
          if (m_err != 16'hFFFF) m_err++;
          if (!m_fvalid) begin
            m_fvec = {8'(j / VECS), va[j], vb[j], vc[j]};
            m_fvalid = 1'b1;
          end
        end
        if (j + 1 < TOTAL) m_op = 8'((j + 1) / VECS);
        else begin
          m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_pass = (m_err == 16'd0);
        end
      end
    end else if (st) begin
      m_active = 1'b1; m_t = 0; m_busy = 1'b1; m_done = 1'b0; m_pass = 1'b0;
      m_err = '0; m_fvalid = 1'b0; m_fvec = '0; m_op = '0;
    end
  endtask

  // Drive inputs for one cycle, clock it, update model, return at negedge.
  task automatic tick(input logic st, input logic ab);
    logic mo;
    mo = cur_miter();
    bus.start = st; bus.abort = ab; bus.miter_out = mo;
    @(posedge clk);
    model_edge(st, ab, mo);
    @(negedge clk);
  endtask

  task automatic run_sweep(input int mode, input logic idle, input int extra_start_at,
                           input logic pin, output int cyc);
    fail_mode = mode; idle_miter = idle;
    tick(1'b1, 1'b0);
    chk("start_err_clr", bus.err_count, 16'd0);
    chk("start_fv_clr", bus.fail_valid, 1'b0);
    chk("start_busy", bus.busy, 1'b1);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < SWEEP_CYC + 20) begin
      tick(cyc == extra_start_at, 1'b0);
      cyc++;
      if (pin && cyc == 1) begin
        chk("vec0_a", bus.a, 16'h0001); chk("vec0_b", bus.b, 16'h000E); chk("vec0_c", bus.carry_in, 1'b0);
      end
      if (pin && cyc == 3) begin
        chk("vec1_a", bus.a, 16'h0000); chk("vec1_b", bus.b, 16'h0007); chk("vec1_c", bus.carry_in, 1'b0);
      end
    end
    chk("sweep_cycles", 64'(cyc), 64'(SWEEP_CYC));
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a", bus.a, m_a);
      chk("b", bus.b, m_b);
      chk("carry_in", bus.carry_in, m_cin);
      chk("opcode", bus.opcode, m_op);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("pass", bus.pass, m_pass);
      chk("err_count", bus.err_count, m_err);
      chk("fail_valid", bus.fail_valid, m_fvalid);
      chk("fail_vec", bus.fail_vec, m_fvec);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l;
    int cyc;
    int guard;
    bus.start = 1'b0; bus.abort = 1'b0; bus.miter_out = 1'b1;
    fail_mode = 0; idle_miter = 1'b1;
    l = 16'hACE1;
    for (int k = 0; k < TOTAL; k++) begin
      va[k] = {12'h000, l[3:0]};
      vb[k] = {12'h000, l[7:4]};
      vc[k] = l[8];
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_fvec", bus.fail_vec, 41'd0);
    rst = 1'b0;
    tick(1'b0, 1'b0);

    // abort wins over start: stays idle
    tick(1'b1, 1'b1);
    chk("abort_vs_start", bus.busy, 1'b0);
    tick(1'b0, 1'b0);

    // sweep, miter always agrees; a start pulse mid-sweep is ignored
    run_sweep(0, 1'b1, 50, 1'b1, cyc);
    chk("s1_pass", bus.pass, 1'b1);
    chk("s1_err", bus.err_count, 16'd0);
    chk("s1_fv", bus.fail_valid, 1'b0);
    chk("s1_op", bus.opcode, 8'd21);
    repeat (3) tick(1'b0, 1'b0);

    // miter tied 0: every sampled vector counts, first one captured
    run_sweep(2, 1'b0, -1, 1'b0, cyc);
    chk("all_err", bus.err_count, 16'(TOTAL));
    chk("all_fvec", bus.fail_vec, {8'd0, 16'h0001, 16'h000E, 1'b0});
    chk("all_pass", bus.pass, 1'b0);

    // back-to-back: failures only on opcode 5
    run_sweep(1, 1'b1, -1, 1'b0, cyc);
    chk("op5_err", bus.err_count, 16'd10);
    chk("op5_pass", bus.pass, 1'b0);
    chk("op5_fv", bus.fail_valid, 1'b1);
    chk("op5_fop", bus.fail_vec[40:33], 8'd5);
    chk("op5_fab", bus.fail_vec[32:0], {va[50], vb[50], vc[50]});

    // miter low only outside SAMPLE: must be ignored
    run_sweep(0, 1'b0, -1, 1'b0, cyc);
    chk("noise_err", bus.err_count, 16'd0);
    chk("noise_pass", bus.pass, 1'b1);

    // abort at cycle 100
    fail_mode = 2; idle_miter = 1'b1;
    tick(1'b1, 1'b0);
    repeat (99) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    repeat (4) tick(1'b0, 1'b0);

    // async reset in the middle of a SAMPLE cycle
    fail_mode = 0;
    tick(1'b1, 1'b0);
    guard = 0;
    while (!(m_active && (m_t % 2 == 1) && m_t > 20) && guard < 100) begin
      tick(1'b0, 1'b0);
      guard++;
    end
    rst = 1'b1;
    #1;
    chk("arst_a", bus.a, 16'd0);
    chk("arst_op", bus.opcode, 8'd0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_err", bus.err_count, 16'd0);
    chk("arst_fvec", bus.fail_vec, 41'd0);
    model_reset();
    @(negedge clk);
    tick(1'b0, 1'b0);
    rst = 1'b0;
    run_sweep(0, 1'b1, -1, 1'b1, cyc);
    chk("post_rst_pass", bus.pass, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
